conv_acc_seq: RTL and testbench

//  Tap sequencer for the conv accumulator. Takes one output-tile job (base, length, tap count, shift, tag) and runs it as
//  one pass per kernel tap. Each pass: pulse start, hold the accumulator control word, open the feeder gate,

---
 rtl/conv_acc_seq_pkg.sv | 22 ++
 rtl/seq_beat_cnt.sv | 25 ++
 rtl/conv_acc_seq.sv | 142 ++++++++++++++
 tb/tb_conv_acc_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_seq_pkg.sv
// Shared types and acc_ctrl field positions for the conv accumulator tap sequencer.
package conv_acc_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEAD,
      S_RUN,
      S_WB,
      S_DRAIN,
      S_DONE
   } seq_state_t;

   localparam int CTRL_FIRST     = 0;
   localparam int CTRL_LAST      = 1;
   localparam int CTRL_SHIFT_LSB = 2;
   localparam int CTRL_SHIFT_W   = 3;
   localparam int CTRL_TAG_LSB   = 5;
   localparam int CTRL_TAG_W     = 14;
   localparam int SIZE_W         = 10;
   localparam int CNT_W          = 11;

endpackage

// File: rtl/seq_beat_cnt.sv
// Saturating 11-bit event counter with synchronous clear and a terminal-value compare.
module seq_beat_cnt
   import conv_acc_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] lim,
   output logic             at_lim
);

   logic [CNT_W-1:0] cnt;

   // Holding at the limit keeps at_lim asserted so overruns are visible.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (inc && !at_lim)
         cnt <= cnt + CNT_W'(1);
   end

   assign at_lim = (cnt == lim);

endmodule

// File: rtl/conv_acc_seq.sv
// Tap sequencer: runs one output-tile job as one accumulator pass per kernel tap.
module conv_acc_seq
   import conv_acc_seq_pkg::*;
#(
   parameter int AW   = 10,
   parameter int TW   = 4,
   parameter int CW1  = 28,
   parameter int LEAD = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [AW-1:0]     cfg_base,
   input  logic [SIZE_W-1:0] cfg_size,
   input  logic [TW-1:0]     cfg_ntap,
   input  logic [2:0]        cfg_shift,
   input  logic [13:0]       cfg_tag,
   output logic              acc_start,
   output logic [AW-1:0]     acc_base,
   output logic [SIZE_W-1:0] acc_size,
   output logic [CW1-1:0]    acc_ctrl,
   output logic              feed_en,
   input  logic              beat_fire,
   input  logic              wb_valid,
   input  logic              out_valid,
   output logic [TW-1:0]     tap_idx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int LCW = $clog2(LEAD + 1);

   seq_state_t        state, state_nxt;
   logic [AW-1:0]     base_q;
   logic [SIZE_W-1:0] size_q;
   logic [TW-1:0]     ntap_q, tap_q;
   logic [CW1-1:0]    ctrl_q;
   logic [LCW-1:0]    lead_q;
   logic              err_q;

   logic              accept, wb_exit, cnt_clr, cnt_st, wb_st, err_now;
   logic              beat_hit, wb_hit, out_hit;
   logic [CNT_W-1:0]  lim_beat, lim_pass;

   assign lim_beat = {1'b0, size_q};
   assign lim_pass = {1'b0, size_q} + CNT_W'(1);
   assign accept   = (state == S_IDLE) && cfg_valid;
   assign cnt_clr  = accept || wb_exit;
   assign cnt_st   = state inside {S_LEAD, S_RUN, S_WB, S_DRAIN};
   assign wb_st    = state inside {S_LEAD, S_RUN, S_WB};

   seq_beat_cnt u_beat_cnt (.clk(clk), .rst(rst), .clr(cnt_clr),
                            .inc(beat_fire && state == S_RUN), .lim(lim_beat), .at_lim(beat_hit));
   seq_beat_cnt u_wb_cnt   (.clk(clk), .rst(rst), .clr(cnt_clr),
                            .inc(wb_valid && cnt_st), .lim(lim_pass), .at_lim(wb_hit));
   seq_beat_cnt u_out_cnt  (.clk(clk), .rst(rst), .clr(cnt_clr),
                            .inc(out_valid && cnt_st), .lim(lim_pass), .at_lim(out_hit));

   // Protocol checks only flag; they never steer the FSM.
   assign err_now = (beat_fire && state != S_RUN)
                  | (wb_valid && (!wb_st || wb_hit))
                  | (out_valid && (!ctrl_q[CTRL_LAST] || out_hit));

   always_comb begin
      state_nxt = state;
      cfg_ready = 1'b0;
      acc_start = 1'b0;
      feed_en   = 1'b0;
      done      = 1'b0;
      wb_exit   = 1'b0;
      case (state)
         S_IDLE: begin
            cfg_ready = 1'b1;
            if (cfg_valid) state_nxt = S_LEAD;
         end
         S_LEAD: begin
            acc_start = (lead_q == '0);
            if (lead_q == LCW'(LEAD - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            feed_en = 1'b1;
            if (beat_fire && beat_hit) state_nxt = (tap_q < ntap_q) ? S_WB : S_DRAIN;
         end
         S_WB: begin
            if (wb_hit) begin
               wb_exit   = 1'b1;
               state_nxt = S_LEAD;
            end
         end
         S_DRAIN: begin
            if (out_hit) state_nxt = S_DONE;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         base_q <= '0;
         size_q <= '0;
         ntap_q <= '0;
         tap_q  <= '0;
         ctrl_q <= '0;
         lead_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_nxt;
         lead_q <= (state == S_LEAD) ? lead_q + LCW'(1) : '0;
         err_q  <= (err_q & ~accept) | err_now;
         if (accept) begin
            base_q <= cfg_base;
            size_q <= cfg_size;
            ntap_q <= cfg_ntap;
            tap_q  <= '0;
            ctrl_q <= '0;
            ctrl_q[CTRL_FIRST] <= 1'b1;
            ctrl_q[CTRL_LAST]  <= (cfg_ntap == '0);
            ctrl_q[CTRL_SHIFT_LSB +: CTRL_SHIFT_W] <= cfg_shift;
            ctrl_q[CTRL_TAG_LSB +: CTRL_TAG_W]     <= cfg_tag;
         end else if (wb_exit) begin
            tap_q <= tap_q + TW'(1);
            ctrl_q[CTRL_FIRST] <= 1'b0;
            ctrl_q[CTRL_LAST]  <= (tap_q + TW'(1) == ntap_q);
         end
      end
   end

   assign acc_base = base_q;
   assign acc_size = size_q;
   assign acc_ctrl = ctrl_q;
   assign tap_idx  = tap_q;
   assign busy     = (state != S_IDLE);
   assign err      = err_q;

endmodule

// File: tb/tb_conv_acc_seq.sv
// Directed bench for conv_acc_seq: job table driven through a well-behaved accumulator responder.
module tb_conv_acc_seq;

   logic        clk = 1'b0;
   logic        rst, cfg_valid, cfg_ready;
   logic [9:0]  cfg_base, cfg_size, acc_base, acc_size;
   logic [3:0]  cfg_ntap, tap_idx;
   logic [2:0]  cfg_shift;
   logic [13:0] cfg_tag;
   logic        acc_start, feed_en, beat_fire, wb_valid, out_valid, busy, done, err;
   logic [27:0] acc_ctrl;

   always #5 clk = ~clk;

   conv_acc_seq #(.AW(10), .TW(4), .CW1(28), .LEAD(2)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_base(cfg_base), .cfg_size(cfg_size), .cfg_ntap(cfg_ntap),
      .cfg_shift(cfg_shift), .cfg_tag(cfg_tag), .acc_start(acc_start),
      .acc_base(acc_base), .acc_size(acc_size), .acc_ctrl(acc_ctrl),
      .feed_en(feed_en), .beat_fire(beat_fire), .wb_valid(wb_valid),
      .out_valid(out_valid), .tap_idx(tap_idx), .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [3:0]  ntap;
      logic [9:0]  size;
      logic [9:0]  base;
      logic [2:0]  shift;
      logic [13:0] tag;
      int          starts;
      int          beats;
      logic [7:0]  fl;     // {last,first} per pass, pass 0 in bits [1:0]
      int          cyc;    // edges from accept to the done cycle
      logic [31:0] ctrl0;  // acc_ctrl at the first start
   } vec_t;

   vec_t tbl[5];
   int   checks = 0;
   int   errors = 0;

   int          r_cyc, r_starts, r_beats;
   logic [7:0]  r_fl;
   logic [31:0] r_ctrl0;
   logic [3:0]  r_tap;
   logic        r_err, r_ok, found;
   int          dn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [3:0] ntap, input logic [9:0] size, input logic [9:0] base,
                         input logic [2:0] shift, input logic [13:0] tag);
      cfg_valid = 1'b1; cfg_ntap = ntap; cfg_size = size; cfg_base = base;
      cfg_shift = shift; cfg_tag = tag;
      tick;
      cfg_valid = 1'b0;
   endtask

   // Always-ready feeder: write-back / final beat echoed in the same cycle as each beat.
   task automatic drive_resp;
      beat_fire = feed_en;
      wb_valid  = feed_en && !acc_ctrl[1];
      out_valid = feed_en && acc_ctrl[1];
   endtask

   task automatic serve(input logic [9:0] base, input logic [9:0] size,
                        output int cyc, output int starts, output int beats, output logic [7:0] fl,
                        output logic [31:0] ctrl0, output logic [3:0] tap_done,
                        output logic err_done, output logic ok);
      cyc = -1; starts = 0; beats = 0; fl = '0; ctrl0 = '0; tap_done = '0; err_done = 1'b0; ok = 1'b1;
      for (int k = 0; k < 1200; k++) begin
         if (acc_start) begin
            if (starts < 4) fl[2*starts +: 2] = acc_ctrl[1:0];
            if (starts == 0) ctrl0 = 32'(acc_ctrl);
            if (acc_base !== base || acc_size !== size || tap_idx !== 4'(starts)) ok = 1'b0;
            starts++;
         end
         if (cfg_ready && busy) ok = 1'b0;
         if (done) begin
            cyc = k; tap_done = tap_idx; err_done = err;
            break;
         end
         drive_resp();
         if (feed_en) beats++;
         tick;
      end
      beat_fire = 1'b0; wb_valid = 1'b0; out_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_base = '0; cfg_size = '0; cfg_ntap = '0;
      cfg_shift = '0; cfg_tag = '0; beat_fire = 1'b0; wb_valid = 1'b0; out_valid = 1'b0;

      tbl[0] = '{4'd2, 10'd3,    10'h040, 3'd5, 14'h1ABC, 3, 12,   8'h21, 21,   32'h35795};
      tbl[1] = '{4'd0, 10'd0,    10'h3FF, 3'd7, 14'h3FFF, 1, 1,    8'h03, 4,    32'h7FFFF};
      tbl[2] = '{4'd1, 10'd0,    10'h155, 3'd0, 14'h0000, 2, 2,    8'h09, 8,    32'h00001};
      tbl[3] = '{4'd3, 10'd1,    10'h2AA, 3'd2, 14'h2001, 4, 8,    8'h81, 20,   32'h40029};
      tbl[4] = '{4'd0, 10'd1023, 10'h000, 3'd1, 14'h0005, 1, 1024, 8'h03, 1027, 32'h000A7};

      repeat (3) tick;
      chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_start",     32'(acc_start), 32'd0);
      chk("rst_feed_en",   32'(feed_en),   32'd0);
      chk("rst_acc_ctrl",  32'(acc_ctrl),  32'd0);
      chk("rst_acc_base",  32'(acc_base),  32'd0);
      chk("rst_tap_idx",   32'(tap_idx),   32'd0);
      chk("rst_done",      32'(done),      32'd0);
      chk("rst_err",       32'(err),       32'd0);
      rst = 1'b0;
      tick;

      for (int i = 0; i < 5; i++) begin
         accept(tbl[i].ntap, tbl[i].size, tbl[i].base, tbl[i].shift, tbl[i].tag);
         serve(tbl[i].base, tbl[i].size, r_cyc, r_starts, r_beats, r_fl, r_ctrl0, r_tap, r_err, r_ok);
         chk($sformatf("row%0d_starts", i),   32'(r_starts), 32'(tbl[i].starts));
         chk($sformatf("row%0d_beats", i),    32'(r_beats),  32'(tbl[i].beats));
         chk($sformatf("row%0d_firstlast", i), 32'(r_fl),    32'(tbl[i].fl));
         chk($sformatf("row%0d_done_cyc", i), 32'(r_cyc),    32'(tbl[i].cyc));
         chk($sformatf("row%0d_ctrl0", i),    r_ctrl0,       tbl[i].ctrl0);
         chk($sformatf("row%0d_tap_done", i), 32'(r_tap),    32'(tbl[i].ntap));
         chk($sformatf("row%0d_err", i),      32'(r_err),    32'd0);
         chk($sformatf("row%0d_stable", i),   32'(r_ok),     32'd1);
         tick;
      end

      // Final beat and final write-back in the same cycle: WB lasts one cycle.
      accept(4'd1, 10'd2, 10'h0A0, 3'd1, 14'h0011);
      tick; tick;
      chk("t3_run_feed", 32'(feed_en), 32'd1);
      beat_fire = 1'b1; wb_valid = 1'b1;
      repeat (3) tick;
      beat_fire = 1'b0; wb_valid = 1'b0;
      chk("t3_wb_feed_off", 32'(feed_en),   32'd0);
      chk("t3_wb_no_start", 32'(acc_start), 32'd0);
      tick;
      chk("t3_next_start", 32'(acc_start),     32'd1);
      chk("t3_next_tap",   32'(tap_idx),       32'd1);
      chk("t3_next_fl",    32'(acc_ctrl[1:0]), 32'd2);
      serve(10'h0A0, 10'd2, r_cyc, r_starts, r_beats, r_fl, r_ctrl0, r_tap, r_err, r_ok);
      chk("t3_done_cyc", 32'(r_cyc), 32'd6);
      chk("t3_err",      32'(r_err), 32'd0);
      tick;

      // Stray beat during LEAD: err sticks, job still completes.
      accept(4'd0, 10'd1, 10'h011, 3'd0, 14'h0022);
      beat_fire = 1'b1;
      tick;
      beat_fire = 1'b0;
      chk("t4_err_set", 32'(err), 32'd1);
      serve(10'h011, 10'd1, r_cyc, r_starts, r_beats, r_fl, r_ctrl0, r_tap, r_err, r_ok);
      chk("t4_done_cyc",  32'(r_cyc),   32'd4);
      chk("t4_beats",     32'(r_beats), 32'd2);
      chk("t4_err_held",  32'(r_err),   32'd1);
      tick;
      chk("t4_err_idle", 32'(err), 32'd1);

      // cfg_valid held across a whole job.
      cfg_valid = 1'b1; cfg_ntap = 4'd0; cfg_size = 10'd0; cfg_base = 10'h123;
      cfg_shift = 3'd3; cfg_tag = 14'h0033;
      tick;
      chk("t5_err_cleared", 32'(err),       32'd0);
      chk("t5_ready_low",   32'(cfg_ready), 32'd0);
      serve(10'h123, 10'd0, r_cyc, r_starts, r_beats, r_fl, r_ctrl0, r_tap, r_err, r_ok);
      chk("t5_done_cyc",   32'(r_cyc),     32'd4);
      chk("t5_no_reaccept", 32'(r_ok),     32'd1);
      chk("t5_done_ready", 32'(cfg_ready), 32'd0);
      tick;
      chk("t5_idle_ready", 32'(cfg_ready), 32'd1);
      chk("t5_idle_busy",  32'(busy),      32'd0);
      tick;
      chk("t5_reaccept_busy",  32'(busy),      32'd1);
      chk("t5_reaccept_start", 32'(acc_start), 32'd1);
      chk("t5_reaccept_ready", 32'(cfg_ready), 32'd0);
      cfg_valid = 1'b0;
      serve(10'h123, 10'd0, r_cyc, r_starts, r_beats, r_fl, r_ctrl0, r_tap, r_err, r_ok);
      chk("t5_second_done", 32'(r_cyc), 32'd4);
      tick;

      // Write-back while idle is a protocol error.
      wb_valid = 1'b1;
      tick;
      wb_valid = 1'b0;
      chk("idle_wb_err", 32'(err), 32'd1);

      // Reset in the middle of tap 1.
      accept(4'd2, 10'd3, 10'h040, 3'd5, 14'h1ABC);
      chk("t6_err_cleared", 32'(err), 32'd0);
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (tap_idx == 4'd1 && feed_en) begin
            found = 1'b1;
            break;
         end
         drive_resp();
         tick;
      end
      chk("t6_reached_tap1", 32'(found), 32'd1);
      beat_fire = 1'b1; wb_valid = 1'b1;
      tick;
      beat_fire = 1'b0; wb_valid = 1'b0; rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("t6_busy",      32'(busy),      32'd0);
      chk("t6_feed_en",   32'(feed_en),   32'd0);
      chk("t6_acc_ctrl",  32'(acc_ctrl),  32'd0);
      chk("t6_cfg_ready", 32'(cfg_ready), 32'd1);
      chk("t6_tap_idx",   32'(tap_idx),   32'd0);
      dn = 32'(done);
      repeat (5) begin
         tick;
         dn += 32'(done);
      end
      chk("t6_no_done", 32'(dn), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
